// File: rtl/friscv_h.sv
// Shared timer register map, CTRL/STATUS bit positions and responder states.
// Included by the timer and by any firmware test or peripheral that talks to it.
`timescale 1ns/1ps
package friscv_h;

  localparam int TMR_REG_CTRL     = 0;
  localparam int TMR_REG_STATUS   = 1;
  localparam int TMR_REG_PRESCALE = 2;
  localparam int TMR_REG_COMPARE  = 3;
  localparam int TMR_REG_COUNT    = 4;

  localparam int TMR_CTRL_ENABLE      = 0;
  localparam int TMR_CTRL_AUTO_RELOAD = 1;
  localparam int TMR_CTRL_IRQ_EN      = 2;
  localparam int TMR_STATUS_PENDING   = 0;

  localparam logic TMR_RESP_IDLE = 1'b0;
  localparam logic TMR_RESP_BUSY = 1'b1;

  typedef struct packed {
    logic irq_en;
    logic auto_reload;
    logic enable;
  } timer_ctrl_t;

  // Byte-lane merge of a 32-bit register with write data under strobes.
  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/friscv_timer_prescaler.sv
// Prescaler: counts 0..reload while enabled and emits a tick on the last count.
// Only instantiated when FRISCV_TIMER_PRESCALER_EN is defined.
`timescale 1ns/1ps
module friscv_timer_prescaler (
  input  logic        aclk,
  input  logic        srst,
  input  logic        enable,
  input  logic [15:0] reload,
  output logic        tick
);

  logic [15:0] pcnt_q;
  logic [15:0] pcnt_d;

  assign tick = enable && (pcnt_q == reload);

  always_comb begin
    pcnt_d = pcnt_q + 16'd1;
    if (!enable || tick) pcnt_d = '0;
  end

  always_ff @(posedge aclk) begin
    if (srst) pcnt_q <= '0;
    else      pcnt_q <= pcnt_d;
  end

endmodule

// File: rtl/friscv_apb_timer.sv
// APB slave timer: 32-bit prescaled up-counter with compare match, one-shot or
// auto-reload, W1C pending flag and level irq. Prescaler gated by FRISCV_TIMER_PRESCALER_EN.
`timescale 1ns/1ps
module friscv_apb_timer
  import friscv_h::*;
#(
  parameter int ADDRW     = 16,
  parameter int XLEN      = 32,
  parameter int BASE_ADDR = 0
) (
  input  logic              aclk,
  input  logic              srst,
  input  logic              slv_en,
  input  logic              slv_wr,
  input  logic [ADDRW-1:0]  slv_addr,
  input  logic [XLEN-1:0]   slv_wdata,
  input  logic [XLEN/8-1:0] slv_strb,
  output logic [XLEN-1:0]   slv_rdata,
  output logic              slv_ready,
  output logic              timer_irq
);

  localparam int IDXW = ADDRW - 2;

  logic              state_q;
  logic [XLEN-1:0]   rdata_q;
  logic              irq_q;
  timer_ctrl_t       ctrl_q, ctrl_d;
  logic              pending_q, pending_d;
  logic [31:0]       compare_q, compare_d;
  logic [31:0]       count_q, count_d;
  logic [15:0]       prescale_val;
  logic              tick;
  logic              match;
  logic              accept;
  logic              wr_acc;
  logic [31:0]       rd_val;

  // One extra bit catches addresses below BASE_ADDR as a borrow.
  logic [ADDRW:0]    diff;
  logic              in_range;
  logic [IDXW-1:0]   reg_idx;
  logic              unused_addr_lsbs;
  logic              hit_ctrl, hit_status, hit_prescale, hit_compare, hit_count;

  assign diff             = {1'b0, slv_addr} - {1'b0, ADDRW'(BASE_ADDR)};
  assign in_range         = !diff[ADDRW];
  assign reg_idx          = diff[ADDRW-1:2];
  assign unused_addr_lsbs = ^diff[1:0];

  assign hit_ctrl     = in_range && (reg_idx == IDXW'(TMR_REG_CTRL));
  assign hit_status   = in_range && (reg_idx == IDXW'(TMR_REG_STATUS));
  assign hit_prescale = in_range && (reg_idx == IDXW'(TMR_REG_PRESCALE));
  assign hit_compare  = in_range && (reg_idx == IDXW'(TMR_REG_COMPARE));
  assign hit_count    = in_range && (reg_idx == IDXW'(TMR_REG_COUNT));

  assign accept = slv_en && (state_q == TMR_RESP_IDLE);
  assign wr_acc = accept && slv_wr;

`ifdef FRISCV_TIMER_PRESCALER_EN
  logic [15:0] prescale_q, prescale_d;

  assign prescale_val = prescale_q;

  friscv_timer_prescaler u_prescaler (
    .aclk   (aclk),
    .srst   (srst),
    .enable (ctrl_q.enable),
    .reload (prescale_q),
    .tick   (tick)
  );
`else
  assign prescale_val = '0;
  assign tick         = ctrl_q.enable;
`endif

  assign match = tick && (count_q == compare_q);

  always_comb begin
    rd_val = '0;
    if (hit_ctrl)     rd_val = {29'b0, ctrl_q};
    if (hit_status)   rd_val = {31'b0, pending_q};
    if (hit_prescale) rd_val = {16'b0, prescale_val};
    if (hit_compare)  rd_val = compare_q;
    if (hit_count)    rd_val = count_q;
  end

  // Ordering encodes the collision rules: software writes override the tick
  // and the one-shot clear, but a match setting pending overrides W1C.
  always_comb begin
    ctrl_d    = ctrl_q;
    pending_d = pending_q;
    compare_d = compare_q;
    count_d   = count_q;
`ifdef FRISCV_TIMER_PRESCALER_EN
    prescale_d = prescale_q;
`endif
    if (tick) count_d = match ? 32'd0 : count_q + 32'd1;
    if (match && !ctrl_q.auto_reload) ctrl_d.enable = 1'b0;
    if (wr_acc) begin
      if (hit_ctrl && slv_strb[0]) begin
        ctrl_d.enable      = slv_wdata[TMR_CTRL_ENABLE];
        ctrl_d.auto_reload = slv_wdata[TMR_CTRL_AUTO_RELOAD];
        ctrl_d.irq_en      = slv_wdata[TMR_CTRL_IRQ_EN];
      end
      if (hit_status && slv_strb[0] && slv_wdata[TMR_STATUS_PENDING]) pending_d = 1'b0;
      if (hit_compare) compare_d = apply_strb(compare_q, slv_wdata[31:0], slv_strb[3:0]);
      if (hit_count)   count_d   = apply_strb(count_q, slv_wdata[31:0], slv_strb[3:0]);
`ifdef FRISCV_TIMER_PRESCALER_EN
      if (hit_prescale) begin
        if (slv_strb[0]) prescale_d[7:0]  = slv_wdata[7:0];
        if (slv_strb[1]) prescale_d[15:8] = slv_wdata[15:8];
      end
`endif
    end
    if (match) pending_d = 1'b1;
  end

  always_ff @(posedge aclk) begin
    if (srst) begin
      state_q   <= TMR_RESP_IDLE;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
      ctrl_q    <= '0;
      pending_q <= 1'b0;
      compare_q <= '0;
      count_q   <= '0;
`ifdef FRISCV_TIMER_PRESCALER_EN
      prescale_q <= '0;
`endif
    end else begin
      state_q   <= accept ? TMR_RESP_BUSY : TMR_RESP_IDLE;
      rdata_q   <= (accept && !slv_wr) ? XLEN'(rd_val) : '0;
      irq_q     <= pending_q && ctrl_q.irq_en;
      ctrl_q    <= ctrl_d;
      pending_q <= pending_d;
      compare_q <= compare_d;
      count_q   <= count_d;
`ifdef FRISCV_TIMER_PRESCALER_EN
      prescale_q <= prescale_d;
`endif
    end
  end

  assign slv_ready = (state_q == TMR_RESP_BUSY);
  assign slv_rdata = rdata_q;
  assign timer_irq = irq_q;

endmodule
